// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core constants and fetch-path types
package riscv_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

   typedef enum logic {RUN, HALT} fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - QDEPTH-entry synchronous FIFO of fetch entries with flush
// Head reads as all-zero while the FIFO is empty.
module if_fifo
   import riscv_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  logic                    flush_i,
   input  fetch_entry_t            entry_i,
   output fetch_entry_t            head_o,
   output logic [$clog2(QDEPTH):0] count_o
);

   localparam int AW = $clog2(QDEPTH);

   fetch_entry_t  mem_q [QDEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
   end

   assign head_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - RISC-V instruction fetch stage: PC, redirect FSM, fetch queue
// Optional IF_BYPASS_EN forwards memory data straight to decode when the queue is empty.
module if_fetch_stage
   import riscv_pkg::*;
#(
   parameter int           N        = 32,
   parameter logic [N-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int           QDEPTH   = 2
) (
   input  logic         clk,
   input  logic         rst,
   output logic [N-1:0] imem_addr,
   input  logic [N-1:0] imem_rd,
   input  logic         redirect_valid,
   input  logic [N-1:0] redirect_pc,
   output logic         instr_valid,
   input  logic         instr_ready,
   output logic [N-1:0] instr,
   output logic [N-1:0] instr_pc,
   output logic         misaligned
);

   localparam int CW = $clog2(QDEPTH) + 1;

   fetch_state_e  state_q;
   logic [N-1:0]  pc_q;
   logic          misaligned_q;
   logic [CW-1:0] count;
   fetch_entry_t  head;
   fetch_entry_t  wr_entry;
   logic          fetch_en, space, flush, bypass;
   logic          pop, push, fifo_push, fifo_pop;

   // A redirect in RUN flushes and blocks both push and pop that cycle.
   assign fetch_en = (state_q == RUN) && !redirect_valid;
   assign flush    = (state_q == RUN) && redirect_valid;
   assign space    = count < CW'(QDEPTH);

`ifdef IF_BYPASS_EN
   assign bypass = fetch_en && (count == '0);
`else
   assign bypass = 1'b0;
`endif

   assign instr_valid = (count != '0) || bypass;
   assign pop         = instr_valid && instr_ready && fetch_en;
   assign push        = fetch_en && (space || pop);
   assign fifo_push   = push && !(bypass && pop);
   assign fifo_pop    = pop && !bypass;
   assign wr_entry    = '{pc: pc_q, instr: imem_rd};

   if_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (flush),
      .entry_i (wr_entry),
      .head_o  (head),
      .count_o (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         pc_q         <= RESET_PC;
         misaligned_q <= 1'b0;
      end else if (state_q == RUN) begin
         if (redirect_valid) begin
            if (redirect_pc[1:0] == 2'b00) begin
               pc_q <= redirect_pc;
            end else begin
               misaligned_q <= 1'b1;
               state_q      <= HALT;
            end
         end else if (push) begin
            pc_q <= pc_q + N'(INSTR_BYTES);
         end
      end
   end

   assign imem_addr  = pc_q;
   assign instr      = bypass ? imem_rd : head.instr;
   assign instr_pc   = bypass ? pc_q : head.pc;
   assign misaligned = misaligned_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage with randomized stimulus
module tb_if_fetch_stage;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, rst2;
   logic [31:0] imem_addr, imem_rd, redirect_pc;
   logic        redirect_valid, instr_valid, instr_ready, misaligned;
   logic [31:0] instr, instr_pc;
   logic [31:0] imem_addr2, imem_rd2, instr2, instr_pc2;
   logic        instr_valid2, misaligned2;
   logic        redir2_valid = 1'b0;
   logic [31:0] redir2_pc    = 32'h0;
   logic        ready2       = 1'b1;

   int   total = 0;
   int   bad   = 0;
   int   hs    = 0;
   exp_t exp_q[$];
   logic [31:0] model_next;
   bit   model_halted;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'hFFC4_A303;
      if (a == 32'h4) return 32'h0083_2383;
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0013;
   endfunction

   assign imem_rd  = mem_word(imem_addr);
   assign imem_rd2 = mem_word(imem_addr2);

   if_fetch_stage dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc), .misaligned(misaligned)
   );

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_rd(imem_rd2),
      .redirect_valid(redir2_valid), .redirect_pc(redir2_pc),
      .instr_valid(instr_valid2), .instr_ready(ready2),
      .instr(instr2), .instr_pc(instr_pc2), .misaligned(misaligned2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: after reset or an aligned redirect, decode sees target, +4, +8, ... in order.
   task automatic model_fill();
      while (!model_halted && exp_q.size() < 16) begin
         exp_q.push_back('{pc: model_next, instr: mem_word(model_next)});
         model_next += 32'd4;
      end
   endtask

   task automatic model_restart(input logic [31:0] pc);
      exp_q.delete();
      model_next = pc;
      model_fill();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      rst            = 1'b0;
      rst2           = 1'b0;
      redirect_valid = 1'b0;
      model_fill();
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      if (!model_halted) begin
         if (pc[1:0] == 2'b00) begin
            model_restart(pc);
         end else begin
            model_halted = 1'b1;
            exp_q.delete();
         end
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      model_halted = 1'b0;
      model_restart(32'h0);
   endtask

   always @(negedge clk) begin
      if (!rst && !redirect_valid && instr_valid && instr_ready) begin
         hs++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_delivery: got pc %h expected none", instr_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_pc", instr_pc, e.pc);
            chk("sb_instr", instr, e.instr);
         end
      end
   end

   initial begin
      int hs0;
      rst            = 1'b1;
      rst2           = 1'b1;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      model_halted   = 1'b0;
      model_restart(32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
      chk("wrap_rst_addr", imem_addr2, 32'hFFFF_FFFC);

      // First fetch after reset, then one per cycle.
      tick();
      @(negedge clk);
      chk("c0_addr", imem_addr, 32'h0);
      chk("c0_valid", {31'h0, instr_valid}, 32'h0);
      tick();
      @(negedge clk);
      chk("c1_valid", {31'h0, instr_valid}, 32'h1);
      chk("c1_instr", instr, 32'hFFC4_A303);
      chk("c1_pc", instr_pc, 32'h0);
      chk("wrap_c1_pc", instr_pc2, 32'hFFFF_FFFC);
      tick();
      @(negedge clk);
      chk("c2_instr", instr, 32'h0083_2383);
      chk("c2_pc", instr_pc, 32'h4);
      chk("wrap_c2_pc", instr_pc2, 32'h0);

      // Stall decode for five cycles after reset.
      tick();
      instr_ready = 1'b0;
      do_reset();
      tick();
      repeat (4) tick();
      @(negedge clk);
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_head", instr_pc, 32'h0);
      tick();
      hs0 = hs;
      instr_ready = 1'b1;
      repeat (3) tick();
      chk("release_count", hs - hs0, 32'd3);

      // Redirect with a full queue.
      instr_ready = 1'b0;
      repeat (3) tick();
      do_redirect(32'h100);
      tick();
      @(negedge clk);
      chk("redir_valid", {31'h0, instr_valid}, 32'h0);
      chk("redir_addr", imem_addr, 32'h100);
      tick();
      @(negedge clk);
      chk("redir_first_valid", {31'h0, instr_valid}, 32'h1);
      chk("redir_first_pc", instr_pc, 32'h100);

      // Redirect and pop together on a full queue.
      repeat (2) tick();
      instr_ready = 1'b1;
      do_redirect(32'h200);
      tick();
      @(negedge clk);
      chk("redir_pop_valid", {31'h0, instr_valid}, 32'h0);

      hs0 = hs;
      for (int i = 0; i < 1500; i++) begin
         int r;
         tick();
         instr_ready = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 99);
         if (r < 3)       do_redirect($urandom() & 32'hFFFF_FFFC);
         else if (r == 3) do_reset();
      end
      tick();
      chk("throughput_ok", {31'h0, (hs - hs0) >= 300}, 32'h1);

      // Misaligned redirect halts fetch until reset.
      instr_ready = 1'b0;
      do_redirect(32'h300);
      repeat (4) tick();
      @(negedge clk);
      chk("pre_halt_addr", imem_addr, 32'h308);
      tick();
      do_redirect(32'h102);
      tick();
      @(negedge clk);
      chk("mis_flag", {31'h0, misaligned}, 32'h1);
      chk("mis_valid", {31'h0, instr_valid}, 32'h0);
      chk("mis_addr", imem_addr, 32'h308);
      for (int i = 0; i < 10; i++) begin
         tick();
         instr_ready = 1'b1;
         if ($urandom_range(0, 1) != 0) do_redirect($urandom() & 32'hFFFF_FFFC);
         @(negedge clk);
         chk("halt_addr", imem_addr, 32'h308);
         chk("halt_valid", {31'h0, instr_valid}, 32'h0);
         chk("halt_flag", {31'h0, misaligned}, 32'h1);
      end
      tick();
      instr_ready = 1'b0;
      do_reset();
      tick();
      @(negedge clk);
      chk("post_rst_addr", imem_addr, 32'h0);
      chk("post_rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("post_rst_instr", instr, 32'h0);
      chk("post_rst_pc", instr_pc, 32'h0);
      chk("post_rst_misaligned", {31'h0, misaligned}, 32'h0);
      instr_ready = 1'b1;
      repeat (5) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the RISC-V core, directly upstream of the instruction memory. Owns the program counter and drives the memory address each cycle. Captures the returned word together with its PC in a small queue and hands it to decode over a valid/ready handshake. Handles stalls from decode, control-flow redirects and misaligned redirect targets.

## Interface
- N, 32, data/address width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- QDEPTH, 2, fetch-queue entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_addr  out  N  fetch address to instruction memory; combinational copy of pc
- imem_rd  in  N  instruction word from memory, valid in the same cycle as imem_addr
- redirect_valid  in  1  branch/jump redirect request from execute
- redirect_pc  in  N  redirect target
- instr_valid  out  1  queue head valid toward decode
- instr_ready  in  1  decode accepts head this cycle
- instr  out  N  head instruction word
- instr_pc  out  N  PC of head instruction
- misaligned  out  1  sticky flag: redirect target had bits[1:0]≠0

## Operation
- States: RUN, HALT. Reset → RUN.
- RUN, no redirect:
  - push = (count<QDEPTH) | pop.
  - On push, {pc, imem_rd} is enqueued and pc ← pc+4, wrapping mod 2^N.
  - Otherwise pc is held and imem_addr is stable.
- pop = instr_valid & instr_ready; head is dequeued at the edge.
- Redirect has priority over push and pop in the same cycle:
  - queue flushed (count ← 0); no push, no pop.
  - If redirect_pc[1:0]==0: pc ← redirect_pc.
  - Else: misaligned ← 1, state ← HALT, pc unchanged.
- HALT: no push; queue was flushed; instr_valid=0; imem_addr frozen; redirects ignored. Left only by rst.
- Queue empty: instr and instr_pc read 0. Non-empty: they show the head entry.
- Queue full without a pop: pc stalls, and imem_addr repeats the same address.

## Timing
- Reset values:
  - pc=RESET_PC, imem_addr=RESET_PC
  - count=0, instr_valid=0, instr=0, instr_pc=0
  - misaligned=0, state=RUN
- rst asserted mid-operation behaves exactly as at power-on, discarding queued entries.
- Fetch latency: word addressed in cycle t is presented at instr_valid in cycle t+1.
- Redirect sampled at edge e: imem_addr=redirect_pc during cycle after e; first new instruction is valid one cycle later.
- Sustained throughput is one instruction per cycle while instr_ready=1.
- Full queue with pop and push in the same cycle: count unchanged, pc advances.
- misaligned rises the cycle after the offending redirect.

## Configuration
- IF_BYPASS_EN defined: when the queue is empty and push occurs, imem_rd and pc are forwarded combinationally.
  - instr_valid=1, instr=imem_rd, instr_pc=pc in the same cycle, giving 0-cycle latency.
  - If popped that cycle, the entry is not stored.
- Not defined: strictly registered output with 1-cycle latency as above.

## Structure
- Shared package riscv_pkg:
  - RESET_PC default
  - INSTR_BYTES=4
  - NOP encoding 32'h0000_0013
  - fetch-state enum {RUN, HALT}
  - fetch-entry struct {pc, instr}
- Sub-module if_fifo: QDEPTH-entry synchronous FIFO of fetch entries with push, pop, flush, count, head outputs. The top owns pc, the FSM and redirect logic.

## Test plan
- Reset, memory[0]=FFC4A303, memory[1]=00832383, instr_ready=1:
  - cycle 1: instr_valid=1, instr=FFC4A303, instr_pc=0.
  - cycle 2: instr=00832383, instr_pc=4.
- instr_ready=0 for 5 cycles after reset:
  - queue fills to 2; imem_addr holds 8.
  - on release, PCs 0, 4, 8 delivered in order with no loss or duplicate.
- Queue full, redirect_valid=1, redirect_pc=0x100:
  - next cycle instr_valid=0, imem_addr=0x100.
  - cycle after, instr_pc=0x100.
- Redirect and pop together with a full queue: flush wins, count=0, no entry is delivered twice.
- redirect_pc=0x102:
  - misaligned=1 next cycle; instr_valid stays 0; imem_addr frozen for 10 cycles.
  - rst clears all outputs to reset values.
- RESET_PC=0xFFFF_FFFC, instr_ready=1: delivered PCs 0xFFFF_FFFC then 0x0000_0000 (wrap).
